bcd_ascii_tx_sequencer: RTL and testbench

BCD_ASCII_TX_SEQUENCER -- requirements
Module: bcd_ascii_tx_sequencer

---
 rtl/bcd_ascii_tx_sequencer.sv | 136 +++++++++++++
 tb/tb_bcd_ascii_tx_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/bcd_ascii_tx_sequencer.sv
// Streams a packed BCD word out as ASCII bytes over a valid/ready byte port:
// optional '-' sign, digits MSB first (optionally without leading zeros), optional CR LF.
module bcd_ascii_tx_sequencer #(
    parameter int NDIGITS     = 8,
    parameter bit LZ_SUPPRESS = 1,
    parameter bit TERM_EN     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NDIGITS-1:0] in_bcd,
    input  logic                 in_neg,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_data,
    output logic                 out_last,
    output logic                 bad_digit
);

    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SIGN,
        DIGIT,
        CR,
        LF
    } state_t;

    state_t                 state, state_d;
    logic [4*NDIGITS-1:0]   word, word_d;
    logic [IW-1:0]          idx, idx_d;
    logic [IW-1:0]          start_idx;
    logic [3:0]             nibble;

    // First digit to send: the most significant nonzero nibble (digit 0 if all zero).
    always_comb begin
        start_idx = LZ_SUPPRESS ? '0 : IW'(NDIGITS - 1);
        if (LZ_SUPPRESS) begin
            for (int i = 0; i < NDIGITS; i++) begin
                if (in_bcd[4*i +: 4] != 4'd0)
                    start_idx = IW'(i);
            end
        end
    end

    always_comb begin
        nibble = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (idx == IW'(i))
                nibble = word[4*i +: 4];
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves one
    // unassigned; otherwise synthesis would infer a latch to hold the old value.
    always_comb begin
        state_d   = state;
        word_d    = word;
        idx_d     = idx;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = 8'h00;
        out_last  = 1'b0;
        bad_digit = 1'b0;

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    word_d  = in_bcd;
                    idx_d   = start_idx;
                    state_d = in_neg ? SIGN : DIGIT;
                end
            end

            SIGN: begin
                out_valid = 1'b1;
                out_data  = 8'h2D;
                if (out_ready)
                    state_d = DIGIT;
            end

            DIGIT: begin
                out_valid = 1'b1;
                if (nibble > 4'd9) begin
                    out_data  = 8'h3F;
                    bad_digit = 1'b1;
                end else begin
                    out_data  = {4'h3, nibble};
                end
                out_last = !TERM_EN && (idx == '0);
                if (out_ready) begin
                    if (idx == '0)
                        state_d = TERM_EN ? CR : IDLE;
                    else
                        idx_d = idx - 1'b1;
                end
            end

            CR: begin
                out_valid = 1'b1;
                out_data  = 8'h0D;
                if (out_ready)
                    state_d = LF;
            end

            LF: begin
                out_valid = 1'b1;
                out_data  = 8'h0A;
                out_last  = 1'b1;
                if (out_ready)
                    state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update
    // together from pre-edge values; the latched word is reset too so an aborted
    // message leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            word  <= '0;
            idx   <= '0;
        end else begin
            state <= state_d;
            word  <= word_d;
            idx   <= idx_d;
        end
    end

endmodule

// File: tb/tb_bcd_ascii_tx_sequencer.sv
// Directed self-checking bench for bcd_ascii_tx_sequencer: default-parameter DUT plus a
// LZ_SUPPRESS=0 instance sharing the same inputs for the no-suppression case.
module tb_bcd_ascii_tx_sequencer;

    typedef logic [7:0] bq_t[$];

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_bcd;
    logic        in_neg;
    logic        out_ready;

    logic        in_ready,  out_valid,  out_last,  bad_digit;
    logic [7:0]  out_data;
    logic        in_ready1, out_valid1, out_last1, bad_digit1;
    logic [7:0]  out_data1;

    int n_checks = 0;
    int n_pass   = 0;

    bcd_ascii_tx_sequencer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_bcd(in_bcd), .in_neg(in_neg), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .bad_digit(bad_digit)
    );

    bcd_ascii_tx_sequencer #(.NDIGITS(8), .LZ_SUPPRESS(0), .TERM_EN(1)) dut_nolz (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_bcd(in_bcd), .in_neg(in_neg), .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_last(out_last1), .bad_digit(bad_digit1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Present one message for a single cycle, then scramble the inputs mid-message.
    task automatic send(input logic [31:0] bcd, input logic neg);
        in_valid = 1'b1;
        in_bcd   = bcd;
        in_neg   = neg;
        check("in_ready_before_send", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_bcd   = 32'hFFFF_FFFF;
        in_neg   = ~neg;
    endtask

    task automatic collect(input string tag, input bq_t exp, input int bad_pos, input bit bp);
        logic [7:0] hd;
        logic       hl, hb, stalled;
        int         n;
        stalled = 1'b0;
        hd = '0; hl = 1'b0; hb = 1'b0;
        n = 0;
        for (int cyc = 0; cyc < 200 && n < exp.size(); cyc++) begin
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled) begin
                check({tag, "_hold_valid"}, out_valid, 1);
                check({tag, "_hold_data"}, out_data, hd);
                check({tag, "_hold_last"}, out_last, hl);
                check({tag, "_hold_bad"}, bad_digit, hb);
            end
            if (!bp)
                check({tag, "_no_bubble"}, out_valid, 1);
            if (out_valid && out_ready) begin
                check({tag, "_data"}, out_data, exp[n]);
                check({tag, "_last"}, out_last, n == exp.size() - 1);
                check({tag, "_bad"}, bad_digit, n == bad_pos);
                n++;
                stalled = 1'b0;
            end else begin
                stalled = out_valid;
                hd = out_data;
                hl = out_last;
                hb = bad_digit;
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        check({tag, "_byte_count"}, n, exp.size());
        check({tag, "_idle_valid"}, out_valid, 0);
        check({tag, "_idle_ready"}, in_ready, 1);
    endtask

    initial begin
        bq_t got0, got1, exp0, exp1;

        rst_n = 1'b0; in_valid = 1'b0; in_bcd = '0; in_neg = 1'b0; out_ready = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_last", out_last, 0);
        check("rst_bad_digit", bad_digit, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // All-zero word on both instances: suppressed vs full width.
        send(32'h0, 1'b0);
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (out_valid)  got0.push_back(out_data);
            if (out_valid1) got1.push_back(out_data1);
            @(negedge clk);
        end
        exp0 = '{8'h30, 8'h0D, 8'h0A};
        exp1 = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
        check("zero_lz_count", got0.size(), exp0.size());
        for (int i = 0; i < exp0.size() && i < got0.size(); i++)
            check("zero_lz_byte", got0[i], exp0[i]);
        check("zero_nolz_count", got1.size(), exp1.size());
        for (int i = 0; i < exp1.size() && i < got1.size(); i++)
            check("zero_nolz_byte", got1[i], exp1[i]);

        send(32'h0000_1234, 1'b0);
        collect("m1234", '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A}, -1, 1'b0);

        send(32'h0000_0507, 1'b1);
        collect("neg507", '{8'h2D, 8'h35, 8'h30, 8'h37, 8'h0D, 8'h0A}, -1, 1'b0);

        send(32'h0000_A012, 1'b0);
        collect("badA012", '{8'h3F, 8'h30, 8'h31, 8'h32, 8'h0D, 8'h0A}, 0, 1'b0);

        send(32'h9876_5432, 1'b0);
        collect("bp98765432", '{8'h39, 8'h38, 8'h37, 8'h36, 8'h35, 8'h34, 8'h33, 8'h32,
                                8'h0D, 8'h0A}, -1, 1'b1);

        // Abort a message with reset after two bytes.
        send(32'h0000_1234, 1'b0);
        check("abort_b0", out_data, 8'h31);
        @(negedge clk);
        check("abort_b1", out_data, 8'h32);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_out_data", out_data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_rst_no_resume", out_valid, 0);

        send(32'h0000_0042, 1'b0);
        collect("m42", '{8'h34, 8'h32, 8'h0D, 8'h0A}, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
